// File: rtl/cache_bus_pkg.sv
// rtl/cache_bus_pkg.sv - shared state encoding, line width helper and line type for the cache bus arbiter
package cache_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_t;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_CHUNKS_LOG = 4;
  localparam int DEF_LINE_W     = DEF_DATA_WIDTH << DEF_CHUNKS_LOG;

  function automatic int line_w(input int data_width, input int chunks_log);
    return data_width * (1 << chunks_log);
  endfunction

  typedef logic [DEF_LINE_W-1:0] line_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first requester after last_grant, wrapping
module rr_pick #(
  parameter int CONNECTIONS = 2,
  localparam int IDX_W      = $clog2(CONNECTIONS)
) (
  input  logic [CONNECTIONS-1:0] req,
  input  logic [IDX_W-1:0]       last_grant,
  output logic [CONNECTIONS-1:0] grant,
  output logic [IDX_W-1:0]       idx
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= CONNECTIONS; k++) begin
      cand = (int'(last_grant) + k) % CONNECTIONS;
      if (!found && ((req & (CONNECTIONS'(1) << cand)) != '0)) begin
        found = 1'b1;
        grant = CONNECTIONS'(1) << cand;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// rtl/cache_bus_arbiter.sv - round-robin arbiter/sequencer from cache requesters to the line bus controller
// Define CACHE_ARB_AGING_EN to add per-requester starvation counters that override round-robin.
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 64,
  parameter int CHUNKS_LOG  = 4,
  parameter int CONNECTIONS = 2,
  parameter int AGE_W       = 4,
  localparam int LINE_W     = line_w(DATA_WIDTH, CHUNKS_LOG)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [CONNECTIONS-1:0]                req_valid,
  input  logic [CONNECTIONS-1:0]                req_store,
  input  logic [CONNECTIONS-1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [CONNECTIONS-1:0][LINE_W-1:0]    req_wdata,
  output logic [CONNECTIONS-1:0]                req_ready,
  output logic [CONNECTIONS-1:0]                resp_valid,
  input  logic [CONNECTIONS-1:0]                resp_ready,
  output logic [LINE_W-1:0]                     resp_data,
  output logic                                  mem_cmd_valid,
  input  logic                                  mem_cmd_ready,
  output logic                                  mem_cmd_store,
  output logic [ADDR_WIDTH-1:0]                 mem_cmd_addr,
  output logic [LINE_W-1:0]                     mem_cmd_wdata,
  input  logic                                  mem_done,
  input  logic [LINE_W-1:0]                     mem_rdata
);

  localparam int IDX_W = $clog2(CONNECTIONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CONNECTIONS - 1);

  if (CONNECTIONS < 2 || AGE_W < 1) begin : g_bad_params
    $error("cache_bus_arbiter: CONNECTIONS must be >= 2 and AGE_W >= 1");
  end

  arb_state_t             state, next_state;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       owner;
  logic                   capture;
  logic [CONNECTIONS-1:0] rr_grant;
  logic [IDX_W-1:0]       rr_idx;
  logic [CONNECTIONS-1:0] win_grant;
  logic [IDX_W-1:0]       win_idx;

  rr_pick #(.CONNECTIONS(CONNECTIONS)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (rr_grant),
    .idx        (rr_idx)
  );

`ifdef CACHE_ARB_AGING_EN
  logic [CONNECTIONS-1:0][AGE_W-1:0] age;
  logic [CONNECTIONS-1:0]            aged;
  logic [CONNECTIONS-1:0]            age_grant;
  logic [IDX_W-1:0]                  age_idx;

  always_comb begin
    aged = '0;
    for (int i = 0; i < CONNECTIONS; i++) begin
      aged[i] = req_valid[i] && (age[i] == '1);
    end
  end

  // Forcing last_grant to the top index makes the picker return the lowest aged requester.
  rr_pick #(.CONNECTIONS(CONNECTIONS)) u_age (
    .req        (aged),
    .last_grant (LAST_IDX),
    .grant      (age_grant),
    .idx        (age_idx)
  );

  assign win_grant = (|aged) ? age_grant : rr_grant;
  assign win_idx   = (|aged) ? age_idx   : rr_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age <= '0;
    end else begin
      for (int i = 0; i < CONNECTIONS; i++) begin
        if (capture && (win_idx == IDX_W'(i))) begin
          age[i] <= '0;
        end else if (req_valid[i] && (age[i] != '1)) begin
          age[i] <= age[i] + AGE_W'(1);
        end
      end
    end
  end
`else
  assign win_grant = rr_grant;
  assign win_idx   = rr_idx;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // req_ready is masked by reset so nothing looks captured while reset is held.
  always_comb begin
    next_state    = state;
    capture       = 1'b0;
    req_ready     = '0;
    resp_valid    = '0;
    mem_cmd_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((|req_valid) && !reset) begin
          capture    = 1'b1;
          req_ready  = win_grant;
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) begin
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_done) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid[owner] = 1'b1;
        if (resp_ready[owner]) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant    <= LAST_IDX;
      owner         <= '0;
      mem_cmd_store <= 1'b0;
      mem_cmd_addr  <= '0;
      mem_cmd_wdata <= '0;
      resp_data     <= '0;
    end else begin
      if (capture) begin
        last_grant    <= win_idx;
        owner         <= win_idx;
        mem_cmd_store <= req_store[win_idx];
        mem_cmd_addr  <= req_addr[win_idx];
        mem_cmd_wdata <= req_wdata[win_idx];
      end
      if ((state == ST_WAIT) && mem_done && !mem_cmd_store) begin
        resp_data <= mem_rdata;
      end
    end
  end

endmodule
